mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised load/store engine for the exec stage; successor to the single-width, fixed-strobe memory path inside exec.
- Accepts one byte, halfword or word access per request, drives a single-beat AXI4 master (AR/R/AW/W/B), and returns load data or a completion to exec.
- Adds byte-lane strobes, sign/zero extension, misalignment detection, AXI error reporting and a wait timeout.

Parameters:
- ADDR_W, 22, byte address width on request and AXI address channels.
- DATA_W, 32, bus and register data width; must be 32 or 64.
- TIMEOUT, 1023, maximum cycles spent waiting in any bus state; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- req_rd  in  5  destination register, carried through
- req_fdest  in  1  destination is the FP register file, carried through
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  extended load data; 0 for stores and errors
- resp_rd  out  5  echoed req_rd
- resp_fdest  out  1  echoed req_fdest
- resp_err  out  1  misaligned access, nonzero rresp/bresp, or timeout
- araddr/awaddr  out  ADDR_W; arsize/awsize  out  3; arvalid/awvalid  out  1; arready/awready  in  1
- rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rready  out  1
- wdata  out  DATA_W; wstrb  out  DATA_W/8; wlast  out  1 (constant 1); wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset: all valid/ready outputs 0, resp_* 0, araddr/awaddr/wdata/wstrb 0, arsize/awsize 0, state IDLE, timeout counter 0.
- req_ready = (state == IDLE). The request is captured into registers on acceptance.
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, ERR.
- IDLE, request accepted, misaligned (half with addr[0], word with addr[1:0] != 0, or size 11):
  - go to ERR; no bus activity.
  - ERR lasts one cycle: resp_valid = 1, resp_err = 1, then IDLE.
- IDLE, load:
  - next cycle arvalid = 1, araddr = req_addr, arsize = {1'b0, req_size}.
  - state RADDR; rready asserted together with arvalid.
- RADDR: on arready, drop arvalid and go to RDATA. rvalid may arrive in the same cycle as arready; accept it there and complete directly.
- RDATA, on rvalid && rready:
  - drop rready.
  - Extract lane = addr[log2(DATA_W/8)-1:0] bytes (shift rdata right by lane*8), mask to size, sign- or zero-extend.
  - Next cycle resp_valid = 1 with that data; resp_err = (rresp != 00).
- IDLE, store:
  - awvalid and wvalid both asserted next cycle.
  - wdata = req_wdata replicated across every lane of the access size.
  - wstrb = size mask (1, 3 or F bytes) shifted left by lane.
  - bready asserted with them; state WRITE.
- WRITE: awvalid and wvalid each drop independently on their own handshake (either order, or simultaneous). Go to WRESP when both have completed.
- WRESP, on bvalid && bready: drop bready; next cycle resp_valid = 1, resp_data = 0, resp_err = (bresp != 00).
- Timeout:
  - Counter clears on every state entry and increments each cycle in RADDR/RDATA/WRITE/WRESP.
  - At TIMEOUT: deassert all valid/ready, resp_valid = 1, resp_err = 1, return to IDLE.
  - This is a debug aid; it knowingly violates AXI valid stability.
- resp_valid has no backpressure and is exactly one cycle wide. The next request can be accepted in the same cycle resp_valid is high.
- Minimum latencies with zero-wait slave, request accepted at cycle 0:
  - load: resp_valid at cycle 3.
  - store: resp_valid at cycle 3.
- rst asserted mid-transaction: the next cycle is the full reset state. Any late rvalid/bvalid is ignored while in IDLE.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - AXI response codes RESP_OKAY/RESP_SLVERR/RESP_DECERR
- Sub-module byte_lane_align (combinational): from addr, size and signed, produce wstrb, replicated wdata and extracted load data. Parametrised on DATA_W.

Test Plan:
- Load word at 0x000104, rdata = 0xDEADBEEF, zero-wait slave -> resp_valid at cycle 3, resp_data = 0xDEADBEEF, resp_err = 0, araddr = 0x104, arsize = 010.
- Signed byte load at 0x000103, rdata = 0x80FF_FF7F -> resp_data = 0xFFFFFF80; the same access unsigned -> 0x00000080.
- Half store 0x1234 at 0x000006 -> wstrb = 1100, wdata = 0x12341234, awsize = 001. awready held off 3 cycles with wready immediate -> single resp_valid only after bvalid.
- Word load at 0x000102 -> no arvalid ever; resp_valid with resp_err = 1 one cycle after acceptance. Store with bresp = 10 -> resp_err = 1.
- TIMEOUT = 8, slave never asserts arready -> arvalid drops after 8 cycles, resp_err = 1, req_ready = 1 the following cycle.
- rst pulsed while in RDATA, then a late rvalid -> no resp_valid; all outputs at reset values; a new request is accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the exec-stage load/store engine: access sizes, FSM states,
// AXI response codes and the alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_WRESP = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The reserved size code is reported as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size_e'(size))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// Combinational lane steering: store strobes and replicated store data, plus
// extraction and sign/zero extension of load data from the addressed lane.
module byte_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int LANE_W = $clog2(STRB_W)
) (
  input  logic [LANE_W-1:0] i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  // Size casts of signed slices perform the sign extension.
  always_comb begin
    o_wstrb = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (size_e'(i_size))
      SZ_BYTE: begin
        o_wstrb = STRB_W'(1) << i_lane;
        o_wdata = {(DATA_W/8){i_wdata[7:0]}};
        o_rdata = i_signed ? DATA_W'($signed(w_shifted[7:0])) : DATA_W'(w_shifted[7:0]);
      end
      SZ_HALF: begin
        o_wstrb = STRB_W'(3) << i_lane;
        o_wdata = {(DATA_W/16){i_wdata[15:0]}};
        o_rdata = i_signed ? DATA_W'($signed(w_shifted[15:0])) : DATA_W'(w_shifted[15:0]);
      end
      SZ_WORD: begin
        o_wstrb = STRB_W'(15) << i_lane;
        o_wdata = {(DATA_W/32){i_wdata[31:0]}};
        o_rdata = i_signed ? DATA_W'($signed(w_shifted[31:0])) : DATA_W'(w_shifted[31:0]);
      end
      default: begin
        o_wstrb = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Exec-stage load/store engine: one byte/half/word access per request over a
// single-beat AXI4 master, with misalignment, bus-error and timeout reporting.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                req_fdest,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_fdest,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  state_e              r_state;
  logic [LANE_W-1:0]   r_lane;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [4:0]          r_rd;
  logic                r_fdest;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic                r_arvalid;
  logic                r_rready;
  logic [ADDR_W-1:0]   r_araddr;
  logic [2:0]          r_arsize;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [2:0]          r_awsize;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [4:0]          r_resp_rd;
  logic                r_resp_fdest;
  logic                r_resp_err;

  logic                w_idle;
  logic                w_busy;
  logic                w_tmo;
  logic                w_misal;
  logic [LANE_W-1:0]   w_al_lane;
  logic [1:0]          w_al_size;
  logic [STRB_W-1:0]   w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_ldata;
  logic                w_rd_err;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_aw_done;
  logic                w_w_done;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_busy  = (r_state == ST_RADDR) || (r_state == ST_RDATA) ||
                   (r_state == ST_WRITE) || (r_state == ST_WRESP);
  assign w_tmo   = (TIMEOUT != 0) && w_busy && (r_tmo_cnt == TMO_LAST);
  assign w_misal = is_misaligned(req_size, req_addr[1:0]);

  // Stores steer from the live request; loads extract using the captured request.
  assign w_al_lane = w_idle ? req_addr[LANE_W-1:0] : r_lane;
  assign w_al_size = w_idle ? req_size : r_size;

  byte_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_lane   (w_al_lane),
    .i_size   (w_al_size),
    .i_signed (r_signed),
    .i_wdata  (req_wdata),
    .i_rdata  (rdata),
    .o_wstrb  (w_wstrb),
    .o_wdata  (w_wdata),
    .o_rdata  (w_ldata)
  );

  assign w_rd_err  = (rresp != RESP_OKAY);
  assign w_rd_data = w_rd_err ? '0 : w_ldata;
  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_rd         <= '0;
      r_fdest      <= 1'b0;
      r_tmo_cnt    <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_awaddr     <= '0;
      r_awsize     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_resp_fdest <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      // Counter runs in bus states; every state change below clears it again.
      r_tmo_cnt    <= w_busy ? r_tmo_cnt + 1'b1 : '0;

      if (w_tmo) begin
        r_arvalid    <= 1'b0;
        r_rready     <= 1'b0;
        r_awvalid    <= 1'b0;
        r_wvalid     <= 1'b0;
        r_bready     <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_data  <= '0;
        r_resp_rd    <= r_rd;
        r_resp_fdest <= r_fdest;
        r_tmo_cnt    <= '0;
        r_state      <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid) begin
              r_lane   <= req_addr[LANE_W-1:0];
              r_size   <= req_size;
              r_signed <= req_signed;
              r_rd     <= req_rd;
              r_fdest  <= req_fdest;
              if (w_misal) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
                r_resp_data  <= '0;
                r_resp_rd    <= req_rd;
                r_resp_fdest <= req_fdest;
                r_state      <= ST_ERR;
              end else if (req_we) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_bready  <= 1'b1;
                r_awaddr  <= req_addr;
                r_awsize  <= {1'b0, req_size};
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
                r_state   <= ST_WRITE;
              end else begin
                r_arvalid <= 1'b1;
                r_rready  <= 1'b1;
                r_araddr  <= req_addr;
                r_arsize  <= {1'b0, req_size};
                r_state   <= ST_RADDR;
              end
            end
          end

          ST_RADDR: begin
            if (arready) begin
              r_arvalid <= 1'b0;
              r_tmo_cnt <= '0;
              // Read data coinciding with the address handshake completes at once.
              if (rvalid) begin
                r_rready     <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_rd_err;
                r_resp_data  <= w_rd_data;
                r_resp_rd    <= r_rd;
                r_resp_fdest <= r_fdest;
                r_state      <= ST_IDLE;
              end else begin
                r_state <= ST_RDATA;
              end
            end
          end

          ST_RDATA: begin
            if (rvalid) begin
              r_rready     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_rd_err;
              r_resp_data  <= w_rd_data;
              r_resp_rd    <= r_rd;
              r_resp_fdest <= r_fdest;
              r_tmo_cnt    <= '0;
              r_state      <= ST_IDLE;
            end
          end

          ST_WRITE: begin
            if (awready) r_awvalid <= 1'b0;
            if (wready)  r_wvalid  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              r_tmo_cnt <= '0;
              r_state   <= ST_WRESP;
            end
          end

          ST_WRESP: begin
            if (bvalid) begin
              r_bready     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= (bresp != RESP_OKAY);
              r_resp_data  <= '0;
              r_resp_rd    <= r_rd;
              r_resp_fdest <= r_fdest;
              r_tmo_cnt    <= '0;
              r_state      <= ST_IDLE;
            end
          end

          ST_ERR: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign resp_fdest = r_resp_fdest;
  assign resp_err   = r_resp_err;
  assign araddr     = r_araddr;
  assign arsize     = r_arsize;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign awaddr     = r_awaddr;
  assign awsize     = r_awsize;
  assign awvalid    = r_awvalid;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign wlast      = 1'b1;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads, stores, misaligned
// accesses, bus errors, timeout and mid-transaction reset.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_signed, req_fdest;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [4:0]    req_rd;
  logic          resp_valid, resp_fdest, resp_err;
  logic [DW-1:0] resp_data;
  logic [4:0]    resp_rd;
  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arsize, awsize;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [4:0]  rd;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_fdest(req_fdest),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_fdest(resp_fdest), .resp_err(resp_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("resp_data",  64'(resp_data),  64'(e.data));
        chk("resp_err",   64'(resp_err),   64'(e.err));
        chk("resp_rd",    64'(resp_rd),    64'(e.rd));
        chk("resp_fdest", 64'(resp_fdest), 64'(e.fd));
        chk("resp_cycle", 64'(cyc),        64'(e.cyc));
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic e, input logic [4:0] rd,
                      input logic fd, input int c);
    exp_t x;
    x.data = d; x.err = e; x.rd = rd; x.fd = fd; x.cyc = c;
    sb_q.push_back(x);
  endtask

  // Drives a request in the current cycle; it is accepted at the coming edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic fd, output int acc);
    chk("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_rd = rd; req_fdest = fd;
    acc = cyc;
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; req_fdest = 1'b0;
  endtask

  task automatic load_zw(input logic [1:0] sz, input logic sg, input logic [AW-1:0] a,
                         input logic [31:0] rdat, input logic [1:0] rr, input logic [4:0] rd,
                         input logic fd, input logic [31:0] exp_d, input logic exp_e);
    int acc;
    issue(1'b0, sz, sg, a, 32'h0, rd, fd, acc);
    push(exp_d, exp_e, rd, fd, acc + 3);
    release_req();
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr",  64'(araddr),  64'(a));
    chk("arsize",  64'(arsize),  64'({1'b0, sz}));
    chk("rready",  64'(rready),  64'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
    rvalid = 1'b1; rdata = rdat; rresp = rr;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    chk("rready_drop", 64'(rready), 64'd0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [1:0] br, input int d, input logic [4:0] rd, input logic fd,
                       input logic [31:0] exp_wd, input logic [3:0] exp_strb);
    int acc;
    issue(1'b1, sz, 1'b0, a, wd, rd, fd, acc);
    push(32'h0, br != 2'b00, rd, fd, acc + 3 + d);
    release_req();
    chk("awvalid", 64'(awvalid), 64'd1);
    chk("wvalid",  64'(wvalid),  64'd1);
    chk("bready",  64'(bready),  64'd1);
    chk("awaddr",  64'(awaddr),  64'(a));
    chk("awsize",  64'(awsize),  64'({1'b0, sz}));
    chk("wdata",   64'(wdata),   64'(exp_wd));
    chk("wstrb",   64'(wstrb),   64'(exp_strb));
    chk("wlast",   64'(wlast),   64'd1);
    wready = 1'b1;
    awready = (d == 0);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      wready = 1'b0;
      chk("wvalid_drop", 64'(wvalid), 64'd0);
      chk("awvalid_hold", 64'(awvalid), 64'd1);
      awready = (i == d);
    end
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("awvalid_drop", 64'(awvalid), 64'd0);
    chk("wvalid_low",   64'(wvalid),  64'd0);
    bvalid = 1'b1; bresp = br;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    chk("bready_drop", 64'(bready), 64'd0);
  endtask

  task automatic misaligned(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                            input logic [4:0] rd, input logic fd);
    int acc;
    issue(we, sz, 1'b0, a, 32'hFFFF_FFFF, rd, fd, acc);
    push(32'h0, 1'b1, rd, fd, acc + 1);
    release_req();
    chk("misal_arvalid", 64'(arvalid), 64'd0);
    chk("misal_awvalid", 64'(awvalid), 64'd0);
    chk("misal_wvalid",  64'(wvalid),  64'd0);
    @(negedge clk);
    chk("misal_arvalid_after", 64'(arvalid), 64'd0);
    chk("misal_awvalid_after", 64'(awvalid), 64'd0);
    chk("misal_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"},  64'(resp_data),  64'd0);
    chk({tag, "_resp_rd"},    64'(resp_rd),    64'd0);
    chk({tag, "_resp_err"},   64'(resp_err),   64'd0);
    chk({tag, "_arvalid"},    64'(arvalid),    64'd0);
    chk({tag, "_rready"},     64'(rready),     64'd0);
    chk({tag, "_awvalid"},    64'(awvalid),    64'd0);
    chk({tag, "_wvalid"},     64'(wvalid),     64'd0);
    chk({tag, "_bready"},     64'(bready),     64'd0);
    chk({tag, "_araddr"},     64'(araddr),     64'd0);
    chk({tag, "_arsize"},     64'(arsize),     64'd0);
    chk({tag, "_awaddr"},     64'(awaddr),     64'd0);
    chk({tag, "_wdata"},      64'(wdata),      64'd0);
    chk({tag, "_wstrb"},      64'(wstrb),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; req_fdest = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Loads: word, signed/unsigned byte and half, positive byte, bus error.
    load_zw(SZ_WORD, 1'b0, 22'h000104, 32'hDEADBEEF, 2'b00, 5'd5,  1'b0, 32'hDEADBEEF, 1'b0);
    load_zw(SZ_BYTE, 1'b1, 22'h000103, 32'h80FFFF7F, 2'b00, 5'd6,  1'b1, 32'hFFFFFF80, 1'b0);
    load_zw(SZ_BYTE, 1'b0, 22'h000103, 32'h80FFFF7F, 2'b00, 5'd7,  1'b0, 32'h00000080, 1'b0);
    load_zw(SZ_HALF, 1'b1, 22'h000002, 32'h80011234, 2'b00, 5'd8,  1'b0, 32'hFFFF8001, 1'b0);
    load_zw(SZ_HALF, 1'b0, 22'h000000, 32'hABCD8765, 2'b00, 5'd9,  1'b1, 32'h00008765, 1'b0);
    load_zw(SZ_BYTE, 1'b1, 22'h000000, 32'h1234567F, 2'b00, 5'd10, 1'b0, 32'h0000007F, 1'b0);
    load_zw(SZ_WORD, 1'b0, 22'h000008, 32'h11223344, 2'b10, 5'd11, 1'b0, 32'h00000000, 1'b1);

    // Stores: delayed awready, byte replication, bus error response.
    store(SZ_HALF, 22'h000006, 32'h00001234, 2'b00, 3, 5'd12, 1'b0, 32'h12341234, 4'b1100);
    store(SZ_BYTE, 22'h000001, 32'hFFFFFFA5, 2'b00, 0, 5'd13, 1'b1, 32'hA5A5A5A5, 4'b0010);
    store(SZ_WORD, 22'h000008, 32'hCAFEF00D, 2'b10, 0, 5'd14, 1'b0, 32'hCAFEF00D, 4'b1111);

    // Misaligned and reserved-size accesses never reach the bus.
    misaligned(1'b0, SZ_WORD, 22'h000102, 5'd15, 1'b0);
    misaligned(1'b0, SZ_RSVD, 22'h000000, 5'd16, 1'b1);
    misaligned(1'b1, SZ_HALF, 22'h000001, 5'd17, 1'b0);

    // Timeout: slave never accepts the address.
    issue(1'b0, SZ_WORD, 1'b0, 22'h000200, 32'h0, 5'd18, 1'b1, acc);
    push(32'h0, 1'b1, 5'd18, 1'b1, acc + 9);
    release_req();
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_arvalid_wait", 64'(arvalid), 64'd1);
      @(negedge clk);
    end
    chk("tmo_arvalid_drop", 64'(arvalid),   64'd0);
    chk("tmo_rready_drop",  64'(rready),    64'd0);
    chk("tmo_req_ready",    64'(req_ready), 64'd1);
    @(negedge clk);

    // Reset while waiting for read data, then a stray rvalid.
    issue(1'b0, SZ_WORD, 1'b0, 22'h000010, 32'h0, 5'd19, 1'b0, acc);
    release_req();
    chk("rst_arvalid", 64'(arvalid), 64'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rst_rready_rdata", 64'(rready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    rvalid = 1'b1; rdata = 32'h55555555; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    chk("midrst_no_resp", 64'(resp_valid), 64'd0);
    chk("midrst_rready",  64'(rready),     64'd0);
    load_zw(SZ_WORD, 1'b0, 22'h000020, 32'h01020304, 2'b00, 5'd20, 1'b0, 32'h01020304, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
